// File: rtl/prng_stream.sv
// Burst-oriented pseudo-random source: LCG or Galois LFSR selected per burst,
// words delivered over a valid/ready stream, generator state kept between bursts.
module prng_stream #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  LCG_A     = WIDTH'(1103515245),
  parameter logic [WIDTH-1:0]  LCG_C     = WIDTH'(12345),
  parameter logic [WIDTH-1:0]  LFSR_TAPS = WIDTH'(32'h8020_0003),
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             mode,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  fsm_t             r_fsm;
  logic [WIDTH-1:0] r_state;
  logic             r_mode;
  logic [CNT_W-1:0] r_remaining;
  logic             r_busy;
  logic             r_done;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  fsm_t             w_fsm_next;
  logic [WIDTH-1:0] w_state_next;
  logic             w_mode_next;
  logic [CNT_W-1:0] w_remaining_next;
  logic             w_busy_next;
  logic             w_done_next;
  logic             w_valid_next;
  logic [WIDTH-1:0] w_data_next;

  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_idle_step;
  logic [WIDTH-1:0] w_run_step;

  // One generator step; a zero LFSR state is treated as 1 so it can never lock up.
  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] s, input logic m);
    logic [WIDTH-1:0] s_nz;
    logic [WIDTH-1:0] res;
    s_nz = (s == '0) ? WIDTH'(1) : s;
    if (!m) res = LCG_A * s + LCG_C;
    else    res = (s_nz >> 1) ^ (s_nz[0] ? LFSR_TAPS : '0);
    return res;
  endfunction

  // A seed loaded on the start edge is the base for the first word.
  assign w_base      = seed_load ? seed : r_state;
  assign w_idle_step = f_step(w_base, mode);
  assign w_run_step  = f_step(r_state, r_mode);

  always_comb begin
    w_fsm_next       = r_fsm;
    w_state_next     = r_state;
    w_mode_next      = r_mode;
    w_remaining_next = r_remaining;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    w_valid_next     = r_valid;
    w_data_next      = r_data;

    case (r_fsm)
      IDLE: begin
        if (seed_load) w_state_next = seed;
        if (start) begin
          if (count != '0) begin
            w_mode_next      = mode;
            w_remaining_next = count;
            w_fsm_next       = RUN;
            w_state_next     = w_idle_step;
            w_data_next      = w_idle_step;
            w_valid_next     = 1'b1;
            w_busy_next      = 1'b1;
          end else begin
            w_done_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (r_valid && out_ready) begin
          if (r_remaining > CNT_W'(1)) begin
            w_remaining_next = r_remaining - CNT_W'(1);
            w_state_next     = w_run_step;
            w_data_next      = w_run_step;
          end else begin
            w_remaining_next = '0;
            w_valid_next     = 1'b0;
            w_busy_next      = 1'b0;
            w_done_next      = 1'b1;
            w_fsm_next       = IDLE;
          end
        end
      end
      default: w_fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= IDLE;
      r_state     <= WIDTH'(1);
      r_mode      <= 1'b0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_valid     <= 1'b0;
      r_data      <= '0;
    end else begin
      r_fsm       <= w_fsm_next;
      r_state     <= w_state_next;
      r_mode      <= w_mode_next;
      r_remaining <= w_remaining_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_valid     <= w_valid_next;
      r_data      <= w_data_next;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = r_valid;
  assign out_data  = r_data;

endmodule
